// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: word-addressed MIPS fetch stage with a QDEPTH-entry instruction queue,
// internal branch/jump target computation and redirect flush. Define FETCH_PERF_EN for perf counters.
module mips_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     IADDR_W  = 10,
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [XLEN-1:0]    inst_pc,
    input  logic               inst_ready,
    input  logic               redirect_valid,
    input  logic               redirect_type,
    input  logic [XLEN-1:0]    redirect_base,
    input  logic [25:0]        redirect_imm,
    output logic               fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [15:0]        perf_flushes
`endif
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [XLEN-1:0]    infl_pc_q, infl_pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             hold_q, hold_d;
    entry_t             mem_q [QDEPTH];

    logic               redirect_take;
    logic               issue;
    logic               enq;
    logic               deq;
    logic               wr_en;
    logic [CNT_W-1:0]   occupancy;
    entry_t             shown;
    logic [XLEN-1:0]    branch_target;
    logic [XLEN-1:0]    jump_target;
    logic [XLEN-1:0]    redirect_target;

    assign branch_target   = redirect_base + XLEN'(1)
                           + {{(XLEN-16){redirect_imm[15]}}, redirect_imm[15:0]};
    assign jump_target     = {redirect_base[XLEN-1:26], redirect_imm};
    assign redirect_target = redirect_type ? jump_target : branch_target;

    // An empty queue shows whatever was on the head last cycle, so inst/inst_pc hold.
    assign shown      = (count_q != '0) ? mem_q[head_q] : hold_q;
    assign inst       = shown.inst;
    assign inst_pc    = shown.pc;
    assign imem_addr  = pc_q[IADDR_W-1:0];
    assign fetch_busy = inflight_q | (count_q != '0);

    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = 1'b0;
        infl_pc_d  = infl_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        hold_d     = shown;

        redirect_take = redirect_valid && (state_q != ST_IDLE);
        occupancy     = count_q + CNT_W'(inflight_q);
        issue         = (state_q != ST_IDLE) && !redirect_take && (occupancy < CNT_W'(QDEPTH));
        inst_valid    = (count_q != '0) && !redirect_take;
        deq           = inst_valid && inst_ready;
        enq           = inflight_q && !redirect_take;
        imem_req      = issue && !reset;
        wr_en         = enq && !reset;

        unique case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = redirect_take ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = redirect_take ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        if (redirect_take) begin
            // Redirect wins over enqueue, dequeue and issue; the in-flight return is dropped.
            pc_d    = redirect_target;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + XLEN'(1);
                inflight_d = 1'b1;
                infl_pc_d  = pc_q;
            end
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            infl_pc_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            infl_pc_q  <= infl_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= '{pc: infl_pc_q, inst: imem_rdata};
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_flushes_q, perf_flushes_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushes_d = perf_flushes_q;
        if (enq && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (redirect_take && (perf_flushes_q != '1)) begin
            perf_flushes_d = perf_flushes_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: doc/mips_fetch_queue.md
Name: mips_fetch_queue

Overview:
Parametrised instruction-fetch stage for the MIPS core; successor to the single-cycle PC/next-PC logic. Owns a word-addressed PC, drives synchronous instruction memory, buffers returned instructions in a QDEPTH-entry queue, and hands them to decode over a valid/ready handshake. Computes branch and jump targets internally, and flushes the queue and any in-flight fetch on redirect.

Parameters:
XLEN, 32, PC/instruction-address width in words.
IADDR_W, 10, instruction memory address width; imem_addr = pc[IADDR_W-1:0].
QDEPTH, 4, queue entries; power of two, at least 2.
RESET_PC, 0, word address loaded into the PC on reset.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request this cycle
imem_addr  out  IADDR_W  word address of the request
imem_rdata  in  32  instruction, valid the cycle after imem_req
inst_valid  out  1  queue head valid
inst  out  32  queue head instruction
inst_pc  out  XLEN  word PC of queue head
inst_ready  in  1  decode accepts head when inst_valid & inst_ready
redirect_valid  in  1  branch taken or jump resolved this cycle
redirect_type  in  1  0 = branch, 1 = jump
redirect_base  in  XLEN  word PC of the branch/jump instruction
redirect_imm  in  26  branch: imm16 in bits [15:0]; jump: target26
fetch_busy  out  1  a fetch is in flight or the queue is non-empty

Behaviour:
- Reset: pc=RESET_PC, queue empty, in-flight flag cleared, state=IDLE. Outputs: imem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_busy=0. Reset overrides all other inputs, including during an in-flight fetch.
- FSM: IDLE -> RUN one cycle after reset deasserts. RUN -> FLUSH on redirect_valid. FLUSH -> RUN after one cycle. The FSM never leaves RUN otherwise.
- Issue in RUN: imem_req=1 when count + inflight < QDEPTH. imem_addr=pc[IADDR_W-1:0]. pc increments by 1 on issue; XLEN wrap is modular.
- Return: the cycle after an issue, imem_rdata and the issuing PC are enqueued unless the fetch was killed.
- Peak throughput: one instruction per cycle with inst_ready held high.
- Output: inst and inst_pc come straight from the queue head. Dequeue occurs on inst_valid & inst_ready. Enqueue and dequeue in the same cycle are both allowed, with count unchanged.
- Full: no issue while count + inflight == QDEPTH, so overflow is impossible. inst_ready=0 for any length of time loses no entry.
- Empty: inst_valid=0; inst and inst_pc hold their last values.
- Redirect, in RUN or FLUSH:
  - Branch target = redirect_base + 1 + sign_extend(redirect_imm[15:0]) to XLEN.
  - Jump target = {redirect_base[XLEN-1:26], redirect_imm}.
  - Effect: queue cleared, in-flight response killed, pc = target, imem_req=0 in the redirect cycle.
  - In FLUSH the first issue is at the target.
  - A redirect takes priority over enqueue and dequeue in the same cycle. The head is not consumed that cycle, and inst_valid is forced to 0 in that cycle.
- Back-to-back redirects: the last one wins; each restarts FLUSH.
- fetch_busy = inflight | (count != 0).

Optional Feature:
FETCH_PERF_EN. When defined, adds two outputs:
- perf_fetched, 32 bits: counts enqueued instructions.
- perf_flushes, 16 bits: counts redirects.
- Both reset to 0 and saturate at all-ones.

When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, inst_ready=1, imem_rdata = 0x20000000 + addr -> imem_addr 0,1,2,... on consecutive cycles; inst_valid first high 2 cycles after IDLE exit; inst_pc 0,1,2 with matching inst every cycle.
- inst_ready=0 for 10 cycles with QDEPTH=4 -> exactly 4 issues then imem_req=0; on release, inst_pc 0,1,2,3 delivered in order, then fetch resumes at 4.
- Branch redirect, base=8, imm16=0xFFFC (-4) -> next issue imem_addr=5; queued and in-flight instructions never appear on inst.
- Jump redirect, base=0x1000_0010, target26=0x0000040 -> next issued pc=0x1000_0040.
- Redirect while full with inst_ready=1 in the same cycle -> no dequeue, inst_valid=0 that cycle, queue empty the next cycle.
- Reset asserted mid-fetch with an in-flight request -> all outputs return to reset values next cycle; the stale imem_rdata is not enqueued. With FETCH_PERF_EN defined, perf_fetched and perf_flushes read 0.
